// File: rtl/shift_pkg.sv
// Shared constants and state encoding for the shift unit arbiter and its shifter.
package shift_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

endpackage

// File: rtl/barrel_shifter.sv
// Logarithmic 8-bit logical shifter: one conditional stage per shift-amount bit,
// zero-filling from whichever end the data moves away from.
module barrel_shifter
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0]  operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] stage [0:SHAMT_W];

    always_comb begin
        stage[0] = operand;
        for (int s = 0; s < SHAMT_W; s++) begin
            if (!shamt[s]) begin
                stage[s+1] = stage[s];
            end else if (dir == DIR_LEFT) begin
                stage[s+1] = stage[s] << (1 << s);
            end else begin
                stage[s+1] = stage[s] >> (1 << s);
            end
        end
    end

    assign result = stage[SHAMT_W];

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin front end that time-shares one barrel_shifter among NUM_REQ clients,
// returning each registered result tagged with the owning requester id.
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*SHAMT_W-1:0]   req_shamt,
    input  logic [NUM_REQ-1:0]           req_dir,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [ID_W-1:0]              rsp_id,
    output logic [CNT_W-1:0]             op_count
);

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    next_ptr;
    logic               grant_found;
    logic               handshake;
    logic [DATA_W-1:0]  op_data;
    logic [SHAMT_W-1:0] op_shamt;
    logic               op_dir;
    logic [ID_W-1:0]    op_id;
    logic [DATA_W-1:0]  shift_out;

    // Scan from ptr upward (wrapping); iterating backwards lets the closest hit win.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx]) begin
                pick = {1'b1, ID_W'(idx)};
            end
        end
        return pick;
    endfunction

    assign {grant_found, grant_id} = rr_pick(req_valid, rr_ptr);
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    barrel_shifter u_shifter (
        .operand (op_data),
        .shamt   (op_shamt),
        .dir     (op_dir),
        .result  (shift_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_data   <= '0;
            op_shamt  <= '0;
            op_dir    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        op_data  <= req_data[grant_id*DATA_W +: DATA_W];
                        op_shamt <= req_shamt[grant_id*SHAMT_W +: SHAMT_W];
                        op_dir   <= req_dir[grant_id];
                        op_id    <= grant_id;
                        rr_ptr   <= next_ptr;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= shift_out;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // The counter holds at all-ones rather than wrapping.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (op_count != '1) begin
                            op_count <= op_count + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Scoreboard bench for shift_unit_arbiter: expected results are queued at issue
// time and popped when the response port presents a result.
module tb_shift_unit_arbiter;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic [11:0] req_shamt;
    logic [3:0]  req_dir;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic [15:0] op_count;

    logic [1:0]  sat_valid;
    logic [1:0]  sat_ready;
    logic [15:0] sat_data;
    logic [5:0]  sat_shamt;
    logic [1:0]  sat_dir;
    logic        sat_rsp_valid;
    logic        sat_rsp_ready;
    logic [7:0]  sat_rsp_data;
    logic [0:0]  sat_rsp_id;
    logic [1:0]  sat_count;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_count = 0;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_shamt (req_shamt),
        .req_dir   (req_dir),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    // Narrow counter instance so saturation is reachable in a few operations.
    shift_unit_arbiter #(.NUM_REQ(2), .ID_W(1), .CNT_W(2)) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (sat_valid),
        .req_ready (sat_ready),
        .req_data  (sat_data),
        .req_shamt (sat_shamt),
        .req_dir   (sat_dir),
        .rsp_valid (sat_rsp_valid),
        .rsp_ready (sat_rsp_ready),
        .rsp_data  (sat_rsp_data),
        .rsp_id    (sat_rsp_id),
        .op_count  (sat_count)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        sat_valid = '0;
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [7:0] d, input logic [2:0] s, input logic dir);
        req_data[8*i +: 8]  = d;
        req_shamt[3*i +: 3] = s;
        req_dir[i]          = dir;
    endtask

    // Presents one request from negedge, queues its expected result and completes
    // the handshake; returns just after the accepting edge with the grant seen.
    task automatic issue_op(input int i, input logic [7:0] d, input logic [2:0] s,
                            input logic dir, input logic [7:0] want,
                            output logic [3:0] gnt, output bit ok);
        exp_t e;
        set_op(i, d, s, dir);
        e.data = want;
        e.id   = 2'(i);
        sb.push_back(e);
        req_valid[i] = 1'b1;
        ok  = 1'b0;
        gnt = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[i]) begin
                ok  = 1'b1;
                gnt = req_ready;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            void'(sb.pop_back());
        end
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #12;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0)    begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00)    begin failures++; $display("[TB] FAIL reset_rsp_data: got %h expected 00", rsp_data); end
        checks++; if (rsp_id !== 2'd0)       begin failures++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        checks++; if (op_count !== 16'd0)    begin failures++; $display("[TB] FAIL reset_op_count: got %0d expected 0", op_count); end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
    endtask

    task automatic test_single_left();
        logic [3:0] gnt;
        bit         ok;
        exp_t       e;
        issue_op(0, 8'd13, 3'd1, DIR_LEFT, 8'd26, gnt, ok);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("[TB] FAIL single_grant: got %b expected 0001", gnt); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_latency_exec: rsp_valid got %b expected 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL single_exec_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_latency_resp: rsp_valid got %b expected 1", rsp_valid); end
        if (rsp_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (rsp_data !== e.data) begin failures++; $display("[TB] FAIL single_data: got %0d expected %0d", rsp_data, e.data); end
            checks++; if (rsp_id !== e.id)     begin failures++; $display("[TB] FAIL single_id: got %0d expected %0d", rsp_id, e.id); end
            consume();
        end else begin
            sb.delete();
            do_reset();
        end
    endtask

    task automatic test_sequential();
        logic [2:0] sh[3]   = '{3'd3, 3'd5, 3'd7};
        logic [7:0] want[3] = '{8'd104, 8'd160, 8'd128};
        logic [3:0] gnt;
        bit         ok;
        exp_t       e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue_op(1, 8'd13, sh[k], DIR_LEFT, want[k], gnt, ok);
            checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL seq_grant%0d: got %b expected 0010", k, gnt); end
            if (!ok) continue;
            wait_rsp(ok);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL seq_timeout%0d: rsp_valid got 0 expected 1", k); end
            if (!ok) continue;
            e = sb.pop_front();
            checks++; if (rsp_data !== e.data || rsp_id !== e.id) begin failures++; $display("[TB] FAIL seq_rsp%0d: got %0d/id%0d expected %0d/id%0d", k, rsp_data, rsp_id, e.data, e.id); end
            consume();
        end
        checks++; if (op_count !== 16'd3) begin failures++; $display("[TB] FAIL seq_op_count: got %0d expected 3", op_count); end
    endtask

    task automatic test_round_robin();
        logic [7:0] want[4] = '{8'd255, 8'd127, 8'd63, 8'd31};
        exp_t       e;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 8'd255, 3'(i), DIR_RIGHT);
        for (int n = 0; n < 8; n++) begin
            e.data = want[n % 4];
            e.id   = 2'(n % 4);
            sb.push_back(e);
        end
        req_valid = 4'hF;
        for (int n = 0; n < 8; n++) begin
            #1;
            checks++; if (req_ready !== 4'(1 << (n % 4))) begin failures++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", n, req_ready, 4'(1 << (n % 4))); end
            @(negedge clk);
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id) begin failures++; $display("[TB] FAIL rr_rsp%0d: got v%b %0d/id%0d expected v1 %0d/id%0d", n, rsp_valid, rsp_data, rsp_id, e.data, e.id); end
            exp_count++;
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rr_one_cycle%0d: rsp_valid got %b expected 0", n, rsp_valid); end
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        checks++; if (op_count !== 16'(exp_count)) begin failures++; $display("[TB] FAIL rr_op_count: got %0d expected %0d", op_count, exp_count); end
    endtask

    task automatic test_stall();
        logic [3:0] gnt;
        bit         ok;
        exp_t       e;
        int         bad;
        issue_op(2, 8'h81, 3'd2, DIR_LEFT, 8'h04, gnt, ok);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL stall_grant: got %b expected 0100", gnt); end
        if (!ok) return;
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL stall_timeout: rsp_valid got 0 expected 1"); end
        if (!ok) begin do_reset(); sb.delete(); return; end
        e = sb.pop_front();
        set_op(0, 8'h11, 3'd1, DIR_LEFT);
        req_valid[0] = 1'b1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || req_ready !== 4'b0000) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0 (data %h id %0d ready %b)", bad, rsp_data, rsp_id, req_ready); end
        req_valid[0] = 1'b0;
        consume();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release: rsp_valid got %b expected 0", rsp_valid); end
        checks++; if (op_count !== 16'(exp_count)) begin failures++; $display("[TB] FAIL stall_op_count: got %0d expected %0d", op_count, exp_count); end
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] gnt;
        bit         ok;
        exp_t       e;
        int         rises;
        issue_op(1, 8'h0F, 3'd4, DIR_LEFT, 8'hF0, gnt, ok);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("[TB] FAIL midrst_grant: got %b expected 0010", gnt); end
        if (ok) void'(sb.pop_back());
        rst_n     = 1'b0;
        req_valid = 4'hF;
        exp_count = 0;
        #2;
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0 || req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_state: got v%b cnt%0d rdy%b expected v0 cnt0 rdy0000", rsp_valid, op_count, req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        rises = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rises++;
        end
        checks++; if (rises != 0) begin failures++; $display("[TB] FAIL midrst_no_rsp: got %0d valid cycles expected 0", rises); end
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL midrst_ptr: got %b expected 0001", req_ready); end
        #1;
        req_valid = '0;
        rises = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) rises++;
        end
        checks++; if (rises != 0) begin failures++; $display("[TB] FAIL withdraw_latched: got %0d valid cycles expected 0", rises); end
        issue_op(2, 8'h3C, 3'd2, DIR_RIGHT, 8'h0F, gnt, ok);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("[TB] FAIL midrst_port2_grant: got %b expected 0100", gnt); end
        if (!ok) return;
        wait_rsp(ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL midrst_port2_timeout: rsp_valid got 0 expected 1"); end
        if (!ok) begin do_reset(); sb.delete(); return; end
        e = sb.pop_front();
        checks++; if (rsp_data !== e.data || rsp_id !== e.id) begin failures++; $display("[TB] FAIL midrst_port2_rsp: got %h/id%0d expected %h/id%0d", rsp_data, rsp_id, e.data, e.id); end
        consume();
        checks++; if (op_count !== 16'(exp_count)) begin failures++; $display("[TB] FAIL midrst_op_count: got %0d expected %0d", op_count, exp_count); end
    endtask

    task automatic test_shamt_zero();
        int         ports[2] = '{0, 3};
        logic       dirs[2]  = '{DIR_LEFT, DIR_RIGHT};
        logic [3:0] gnt;
        bit         ok;
        exp_t       e;
        for (int k = 0; k < 2; k++) begin
            issue_op(ports[k], 8'hA5, 3'd0, dirs[k], 8'hA5, gnt, ok);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL zero_grant%0d: got %b expected a grant", k, gnt); end
            if (!ok) continue;
            wait_rsp(ok);
            checks++; if (!ok) begin failures++; $display("[TB] FAIL zero_timeout%0d: rsp_valid got 0 expected 1", k); end
            if (!ok) begin do_reset(); sb.delete(); continue; end
            e = sb.pop_front();
            checks++; if (rsp_data !== e.data || rsp_id !== e.id) begin failures++; $display("[TB] FAIL zero_rsp%0d: got %h/id%0d expected %h/id%0d", k, rsp_data, rsp_id, e.data, e.id); end
            consume();
        end
    endtask

    task automatic test_saturation();
        bit ok;
        do_reset();
        sat_rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            sat_data[7:0]  = 8'h01;
            sat_shamt[2:0] = 3'(n);
            sat_dir        = 2'b01;
            sat_valid      = 2'b01;
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (sat_ready[0]) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            if (ok) begin @(posedge clk); #1; end
            sat_valid = '0;
            checks++; if (!ok) begin failures++; $display("[TB] FAIL sat_grant%0d: got %b expected 01", n, sat_ready); end
            if (!ok) continue;
            ok = 1'b0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (sat_rsp_valid) begin ok = 1'b1; break; end
            end
            checks++; if (!ok || sat_rsp_data !== 8'(1 << n)) begin failures++; $display("[TB] FAIL sat_rsp%0d: got v%b %h expected v1 %h", n, sat_rsp_valid, sat_rsp_data, 8'(1 << n)); end
            @(negedge clk);
            checks++; if (sat_count !== 2'((n + 1 > 3) ? 3 : n + 1)) begin failures++; $display("[TB] FAIL sat_count%0d: got %0d expected %0d", n, sat_count, (n + 1 > 3) ? 3 : n + 1); end
        end
    endtask

    initial begin
        req_valid     = '0;
        req_data      = '0;
        req_shamt     = '0;
        req_dir       = '0;
        rsp_ready     = 1'b0;
        sat_valid     = '0;
        sat_data      = '0;
        sat_shamt     = '0;
        sat_dir       = '0;
        sat_rsp_ready = 1'b0;
        test_reset();
        test_single_left();
        test_sequential();
        test_round_robin();
        test_stall();
        test_reset_mid_op();
        test_shamt_zero();
        test_saturation();
        checks++; if (sb.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
